// File: rtl/pic16f84_pkg.sv
// Shared types and phase constants for the PIC16F84 quadrature-phase consumer blocks.
package pic16f84_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SYNC   = ST_SYNC,
    LOCKED = ST_LOCKED,
    ERROR  = ST_ERROR
  } seq_state_t;

  localparam logic [3:0] PH_Q1 = 4'b0001;
  localparam logic [3:0] PH_Q2 = 4'b0010;
  localparam logic [3:0] PH_Q3 = 4'b0100;
  localparam logic [3:0] PH_Q4 = 4'b1000;

  // CLKOUT is high during Q3 and Q4 only
  localparam logic [3:0] PH_CLKOUT_HI = PH_Q3 | PH_Q4;

  function automatic logic exp_clk_out(input logic [3:0] p);
    return |(p & PH_CLKOUT_HI);
  endfunction

  function automatic logic [3:0] rotate_phase(input logic [3:0] p);
    return {p[2:0], p[3]};
  endfunction

endpackage

// File: rtl/pic16f84_qphase_check.sv
// Classifies the current phase vector against the previously sampled one.
module pic16f84_qphase_check
  import pic16f84_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic q1,
  input  logic q2,
  input  logic q3,
  input  logic q4,
  input  logic clk_out,
  output logic legal,
  output logic start_ok,
  output logic is_q1,
  output logic is_q2,
  output logic is_q3,
  output logic is_q4,
  output logic all_zero
);

  logic [3:0] p;
  logic [3:0] prev_p;
  logic       one_hot;

  assign p = {q4, q3, q2, q1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_p <= '0;
    else     prev_p <= p;
  end

  // Flags describe the vector being sampled on this edge so the FSM adds only one clk of latency
  always_comb begin
    one_hot  = (p != '0) && ((p & (p - 4'd1)) == '0);
    legal    = one_hot && (p == rotate_phase(prev_p)) && (clk_out == exp_clk_out(p));
    is_q1    = (p == PH_Q1);
    is_q2    = (p == PH_Q2);
    is_q3    = (p == PH_Q3);
    is_q4    = (p == PH_Q4);
    all_zero = (p == '0);
    start_ok = is_q1 && !clk_out;
  end

endmodule

// File: rtl/pic16f84_cycle_sequencer.sv
// Locks onto the Q1..Q4 phase stream and produces registered per-instruction-cycle strobes.
module pic16f84_cycle_sequencer
  import pic16f84_pkg::*;
#(
  parameter int LOCK_CYCLES = 2,
  parameter int CNT_W       = 16,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q1,
  input  logic             q2,
  input  logic             q3,
  input  logic             q4,
  input  logic             clk_out,
  input  logic             flush,
  output logic             locked,
  output logic             read_stb,
  output logic             exec_stb,
  output logic             write_stb,
  output logic             fetch_stb,
  output logic             flush_cycle,
  output logic             phase_err,
  output logic [CNT_W-1:0] icycle_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  seq_state_t state;
  logic [7:0] clean;
  logic       pend;

  logic legal, start_ok, is_q1, is_q2, is_q3, is_q4, all_zero;

  pic16f84_qphase_check u_check (
    .clk      (clk),
    .rst      (rst),
    .q1       (q1),
    .q2       (q2),
    .q3       (q3),
    .q4       (q4),
    .clk_out  (clk_out),
    .legal    (legal),
    .start_ok (start_ok),
    .is_q1    (is_q1),
    .is_q2    (is_q2),
    .is_q3    (is_q3),
    .is_q4    (is_q4),
    .all_zero (all_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      clean       <= '0;
      pend        <= 1'b0;
      locked      <= 1'b0;
      read_stb    <= 1'b0;
      exec_stb    <= 1'b0;
      write_stb   <= 1'b0;
      fetch_stb   <= 1'b0;
      flush_cycle <= 1'b0;
      phase_err   <= 1'b0;
      icycle_cnt  <= '0;
      err_cnt     <= '0;
    end else begin
      read_stb  <= 1'b0;
      exec_stb  <= 1'b0;
      write_stb <= 1'b0;
      fetch_stb <= 1'b0;
      phase_err <= 1'b0;

      case (state)
        IDLE: begin
          if (start_ok) begin
            state <= SYNC;
            clean <= '0;
          end else if (!all_zero) begin
            state <= ERROR;
          end
        end

        ERROR: begin
          if (all_zero) begin
            state <= IDLE;
          end else if (start_ok) begin
            state <= SYNC;
            clean <= '0;
          end
        end

        SYNC, LOCKED: begin
          // Illegal phase wins over flush and counting on the same edge
          if (!legal) begin
            state       <= all_zero ? IDLE : ERROR;
            locked      <= 1'b0;
            pend        <= 1'b0;
            flush_cycle <= 1'b0;
            if (!all_zero) begin
              phase_err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            end
          end else if (state == SYNC) begin
            if (is_q4) begin
              clean <= clean + 8'd1;
              if (clean + 8'd1 == 8'(LOCK_CYCLES)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
          end else begin
            read_stb  <= is_q2;
            exec_stb  <= is_q3 && !flush_cycle;
            write_stb <= is_q4 && !flush_cycle;
            fetch_stb <= is_q4;
            if (is_q4) icycle_cnt <= icycle_cnt + CNT_W'(1);
            // A flush seen on the Q1 edge itself turns the cycle just starting into the NOP
            if (is_q1) begin
              flush_cycle <= pend || flush;
              pend        <= 1'b0;
            end else begin
              pend <= pend || flush;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
